// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave
//   AHB-Lite single-port SRAM slave. A word-organised array sits behind the
//   AHB address/data pipeline:
//   - writes have no wait state;
//   - reads have one wait state;
//   - illegal transfers get the two-cycle ERROR response.
//
// Optional build macro:
//   AHB_MEM_PRELOAD_EN - array starts with word[i] = i+1. When it is not
//                        defined, the contents are unknown until written.
//
// Parameters:
//   MEM_DEPTH  number of 32-bit words
//   AW         word-index width, clog2(MEM_DEPTH)
//
// Ports:
//   hclk       bus clock, rising edge
//   hreset     synchronous active-high reset
//   hsel       slave select from the decoder
//   haddr      byte address (address phase)
//   htrans     IDLE/BUSY/NONSEQ/SEQ
//   hwrite     1 = write
//   hsize      000 byte, 001 half, 010 word
//   hburst     accepted and ignored
//   hreadyin   bus HREADY; the address phase is sampled only when high
//   hwdata     write data (data phase)
//   hrdata     read data, held outside the read data beat
//   hreadyout  slave ready
//   hresp      OKAY=00 / ERROR=01
module ahb_mem_slave #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = 10
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hreadyin,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RDATA = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } state_t;

  typedef logic [31:0] mem_t [MEM_DEPTH];

  // Out of range, illegal size, or misaligned for its size.
  function automatic logic xfer_error(input logic [31:0] addr, input logic [2:0] size);
    logic err;
    err = (addr[31:2] >= 30'(MEM_DEPTH)) || (size > 3'b010);
    if (size == 3'b001 && addr[0] != 1'b0) begin
      err = 1'b1;
    end
    if (size == 3'b010 && addr[1:0] != 2'b00) begin
      err = 1'b1;
    end
    return err;
  endfunction

`ifdef AHB_MEM_PRELOAD_EN
  // Power-up image: word[i] = i+1.
  function automatic mem_t preload_image();
    mem_t img;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      img[i] = 32'(i) + 32'd1;
    end
    return img;
  endfunction

  mem_t mem_r = preload_image();
`else
  mem_t mem_r;
`endif

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [1:0]    lane_r;
  logic [2:0]    size_r;
  logic          accept_s;
  logic [3:0]    wstrb_s;
  logic [31:0]   wmask_s;
  logic          unused_s;

  // hburst and htrans[0] carry no information this slave needs.
  assign unused_s = ^{hburst, htrans[0], 1'b0};
  assign accept_s = hsel & htrans[1] & hreadyin;

  // Byte strobes of the pending write, from the registered size and low address.
  always_comb begin
    wstrb_s = 4'b0000;
    case (size_r)
      3'b000:  wstrb_s = 4'b0001 << lane_r;
      3'b001:  wstrb_s = lane_r[1] ? 4'b1100 : 4'b0011;
      3'b010:  wstrb_s = 4'b1111;
      default: wstrb_s = 4'b0000;
    endcase
    wmask_s = {{8{wstrb_s[3]}}, {8{wstrb_s[2]}}, {8{wstrb_s[1]}}, {8{wstrb_s[0]}}};
  end

  // Transfer FSM with registered bus responses.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r   <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= RESP_OKAY;
      hrdata    <= 32'h0000_0000;
      idx_r     <= {AW{1'b0}};
      lane_r    <= 2'b00;
      size_r    <= 3'b000;
    end else begin
      case (state_r)
        ST_RWAIT: begin
          // Array read one cycle after acceptance, so a write in the
          // previous data phase is already committed.
          state_r   <= ST_RDATA;
          hreadyout <= 1'b1;
          hresp     <= RESP_OKAY;
          hrdata    <= mem_r[idx_r];
        end
        ST_ERR1: begin
          state_r   <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= RESP_ERROR;
        end
        ST_IDLE, ST_WDATA, ST_RDATA, ST_ERR2: begin
          if (accept_s) begin
            idx_r  <= haddr[AW+1:2];
            lane_r <= haddr[1:0];
            size_r <= hsize;
            if (xfer_error(haddr, hsize)) begin
              state_r   <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= RESP_ERROR;
            end else if (hwrite) begin
              state_r   <= ST_WDATA;
              hreadyout <= 1'b1;
              hresp     <= RESP_OKAY;
            end else begin
              state_r   <= ST_RWAIT;
              hreadyout <= 1'b0;
              hresp     <= RESP_OKAY;
            end
          end else begin
            state_r   <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= RESP_OKAY;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= RESP_OKAY;
        end
      endcase
    end
  end

  // Commit the write data phase; a reset on that edge drops the write.
  always_ff @(posedge hclk) begin
    if (!hreset && state_r == ST_WDATA) begin
      mem_r[idx_r] <= (mem_r[idx_r] & ~wmask_s) | (hwdata & wmask_s);
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave
//   Directed bench for ahb_mem_slave. A transfer-level model predicts the
//   response beats of each transfer. It also predicts the held read data and
//   the memory contents. One compare process checks the DUT against the
//   model every cycle. Literal expectations pin selected read values.
module tb_ahb_mem_slave;

  localparam int MEM_DEPTH = 1024;
  localparam int AW        = 10;

  localparam int K_IDLE  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_NOSEL = 2;
  localparam int K_RD    = 3;
  localparam int K_WR    = 4;
  localparam int K_WRRST = 5;

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hreadyin;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  ahb_mem_slave #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hreadyin  (hreadyin),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          lit_on;
    logic [31:0] lit;
  } xfer_t;

  xfer_t q[$];
  xfer_t idle_x;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: memory words, held read data, expected response this cycle.
  logic [31:0] mem_m [int];
  logic [31:0] rdata_m;
  logic        exp_on;
  logic        exp_ready;
  logic [1:0]  exp_resp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    return (a / 4 >= MEM_DEPTH) || (s > 3'd2) ||
           (s == 3'd1 && a % 2 != 0) || (s == 3'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mem_read(input int idx);
    if (mem_m.exists(idx)) return mem_m[idx];
`ifdef AHB_MEM_PRELOAD_EN
    return 32'(idx + 1);
`else
    return 32'h0;
`endif
  endfunction

  // Byte-level write: lanes first .. first+2**size-1 take the new data.
  task automatic mem_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int          idx;
    int          first;
    int          n;
    logic [31:0] w;
    idx   = int'(a / 4);
    first = int'(a % 4);
    n     = 1 << s;
    w     = mem_read(idx);
    for (int b = 0; b < 4; b++) begin
      if (b >= first && b < first + n) w[8*b +: 8] = d[8*b +: 8];
    end
    mem_m[idx] = w;
  endtask

  task automatic add(input int kind, input logic [31:0] a, input logic [2:0] s,
                     input logic [31:0] d, input bit lo, input logic [31:0] l);
    xfer_t x;
    x.kind = kind; x.addr = a; x.size = s; x.wdata = d; x.lit_on = lo; x.lit = l;
    q.push_back(x);
  endtask

  task automatic present(input xfer_t x);
    hsel   = (x.kind != K_NOSEL);
    case (x.kind)
      K_IDLE:  htrans = 2'b00;
      K_BUSY:  htrans = 2'b01;
      default: htrans = 2'b10;
    endcase
    haddr  = x.addr;
    hwrite = (x.kind == K_WR || x.kind == K_WRRST);
    hsize  = x.size;
    hburst = 3'b001;
  endtask

  // Single compare process: DUT outputs against the model, away from the edge.
  always @(negedge hclk) begin
    if (exp_on) begin
      check("hreadyout", {31'd0, hreadyout}, {31'd0, exp_ready});
      check("hresp", {30'd0, hresp}, {30'd0, exp_resp});
      check("hrdata", hrdata, rdata_m);
    end
  end

  initial begin
    exp_on    = 1'b0;
    exp_ready = 1'b1;
    exp_resp  = 2'b00;
    rdata_m   = 32'h0;
    idle_x.kind = K_IDLE; idle_x.addr = 32'h0; idle_x.size = 3'b010;
    idle_x.wdata = 32'h0; idle_x.lit_on = 1'b0; idle_x.lit = 32'h0;
    present(idle_x);
    hreadyin = 1'b1;
    hwdata   = 32'h0;
    hreset   = 1'b1;

`ifdef AHB_MEM_PRELOAD_EN
    add(K_RD, 32'h04, 3'b010, 32'h0, 1'b1, 32'h2);
    add(K_RD, 32'h08, 3'b010, 32'h0, 1'b1, 32'h3);
    add(K_RD, 32'h0C, 3'b010, 32'h0, 1'b1, 32'h4);
    add(K_RD, 32'h00, 3'b010, 32'h0, 1'b1, 32'h1);
`endif
    add(K_WR,    32'h0C, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0);
    add(K_RD,    32'h0C, 3'b010, 32'h0,        1'b1, 32'hDEADBEEF);
    add(K_IDLE,  32'h0C, 3'b010, 32'h0,        1'b0, 32'h0);
    add(K_WR,    32'h00, 3'b010, 32'h11223344, 1'b0, 32'h0);
    add(K_WR,    32'h02, 3'b000, 32'h00AA0000, 1'b0, 32'h0);
    add(K_RD,    32'h00, 3'b010, 32'h0,        1'b1, 32'h11AA3344);
    add(K_RD,    32'h1000, 3'b010, 32'h0,      1'b0, 32'h0);
    add(K_RD,    32'h02, 3'b010, 32'h0,        1'b0, 32'h0);
    add(K_RD,    32'h80000000, 3'b010, 32'h0,  1'b0, 32'h0);
    add(K_RD,    32'h00, 3'b010, 32'h0,        1'b1, 32'h11AA3344);
    add(K_WR,    32'h10, 3'b010, 32'h5,        1'b0, 32'h0);
    add(K_RD,    32'h10, 3'b010, 32'h0,        1'b1, 32'h5);
    add(K_BUSY,  32'h03, 3'b010, 32'h0,        1'b0, 32'h0);
    add(K_WR,    32'h12, 3'b001, 32'hBEEF0000, 1'b0, 32'h0);
    add(K_NOSEL, 32'h1000, 3'b010, 32'h0,      1'b0, 32'h0);
    add(K_WR,    32'h01, 3'b001, 32'hFFFFFFFF, 1'b0, 32'h0);
    add(K_WR,    32'h03, 3'b000, 32'h77000000, 1'b0, 32'h0);
    add(K_RD,    32'h10, 3'b010, 32'h0,        1'b1, 32'hBEEF0005);
    add(K_RD,    32'h00, 3'b010, 32'h0,        1'b1, 32'h77AA3344);
    add(K_RD,    32'h0C, 3'b011, 32'h0,        1'b0, 32'h0);
    add(K_WR,    32'hFFC, 3'b010, 32'hA5A5A5A5, 1'b0, 32'h0);
    add(K_RD,    32'hFFC, 3'b010, 32'h0,       1'b1, 32'hA5A5A5A5);
    add(K_RD,    32'hFFE, 3'b000, 32'h0,       1'b1, 32'hA5A5A5A5);
    add(K_WR,    32'h1004, 3'b010, 32'h12345678, 1'b0, 32'h0);
    add(K_WR,    32'h20, 3'b010, 32'hCAFE0001, 1'b0, 32'h0);
    add(K_WRRST, 32'h20, 3'b010, 32'h99999999, 1'b0, 32'h0);
    add(K_RD,    32'h20, 3'b010, 32'h0,        1'b1, 32'hCAFE0001);
    add(K_RD,    32'h0E, 3'b001, 32'h0,        1'b1, 32'hDEADBEEF);

    // Reset held for two edges, then the reset state is checked.
    repeat (2) @(posedge hclk);
    #1;
    hreset    = 1'b0;
    exp_on    = 1'b1;
    exp_ready = 1'b1;
    exp_resp  = 2'b00;
    rdata_m   = 32'h0;

    for (int k = 0; k < q.size(); k++) begin
      xfer_t x;
      xfer_t nx;
      x  = q[k];
      nx = (k + 1 < q.size()) ? q[k+1] : idle_x;
      present(x);
      hreadyin = 1'b1;
      @(posedge hclk);
      #1;
      if ((x.kind == K_RD || x.kind == K_WR || x.kind == K_WRRST) && is_err(x.addr, x.size)) begin
        // Two ERROR beats, ready low then high; memory untouched.
        exp_ready = 1'b0;
        exp_resp  = 2'b01;
        hwdata    = x.wdata;
        present(nx);
        hreadyin  = 1'b0;
        @(posedge hclk);
        #1;
        exp_ready = 1'b1;
        exp_resp  = 2'b01;
      end else if (x.kind == K_RD) begin
        // One wait state, then the full word.
        exp_ready = 1'b0;
        exp_resp  = 2'b00;
        present(nx);
        hreadyin  = 1'b0;
        @(posedge hclk);
        #1;
        rdata_m   = mem_read(int'(x.addr / 4));
        exp_ready = 1'b1;
        exp_resp  = 2'b00;
        if (x.lit_on) begin
          check("lit_hrdata", hrdata, x.lit);
          check("lit_model", rdata_m, x.lit);
        end
      end else if (x.kind == K_WR || x.kind == K_WRRST) begin
        hwdata    = x.wdata;
        exp_ready = 1'b1;
        exp_resp  = 2'b00;
        if (x.kind == K_WRRST) begin
          // Reset lands on the write's data-phase edge: write dropped.
          hreset = 1'b1;
          present(nx);
          @(posedge hclk);
          #1;
          hreset    = 1'b0;
          rdata_m   = 32'h0;
          exp_ready = 1'b1;
          exp_resp  = 2'b00;
        end else begin
          mem_write(x.addr, x.size, x.wdata);
        end
      end else begin
        exp_ready = 1'b1;
        exp_resp  = 2'b00;
      end
    end

    present(idle_x);
    hreadyin = 1'b1;
    repeat (3) begin
      @(posedge hclk);
      #1;
      exp_ready = 1'b1;
      exp_resp  = 2'b00;
    end
    @(negedge hclk);
    #1;
    exp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
